rr_fanout_dispatcher: RTL
=========================

Name: rr_fanout_dispatcher

Overview:
- Upstream feeder stage for a group of N_OUT sibling leaf instances.
- Accepts one valid/ready input stream into a small FIFO and deals each word to the consumers in strict round-robin order.
- If a consumer stalls past STALL_LIMIT cycles, the current word skips to the next consumer so one dead leaf cannot block the group.
- Exposes dispatch and skip counters for bring-up and debug.

Parameters:
DATA_W, 8, width of each data word
N_OUT, 5, number of downstream consumers (2..8)
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)
STALL_LIMIT, 15, consecutive not-ready cycles tolerated before skipping a consumer (1..255)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream word valid
in_ready  out  1  FIFO can accept; equals (fill < FIFO_DEPTH)
in_data  in  DATA_W  upstream word
out_valid  out  N_OUT  one-hot offer; bit ptr set only while in OFFER
out_ready  in  N_OUT  per-consumer ready
out_data  out  DATA_W  FIFO head word, shared by all consumers
sel_idx  out  3  current round-robin pointer ptr (0..N_OUT-1)
dispatch_cnt  out  16  number of words delivered, wraps at 65535->0
skip_cnt  out  8  number of stall skips, saturates at 255

Behaviour:
- Reset (rst=1 at a rising edge):
  - fill=0, FIFO pointers=0, ptr=0, stall counter=0, state=IDLE.
  - out_valid=0, in_ready=0 during reset, dispatch_cnt=0, skip_cnt=0, out_data=0.
- in_ready: 1 from the first cycle after reset deasserts, while fill<FIFO_DEPTH.
- Push: in_valid & in_ready at an edge; the word is written at the FIFO tail.
- Fill decision uses pre-edge fill. When full, no push is accepted even if a pop occurs in the same cycle (no bypass).
- Minimum latency: a word pushed at edge N is offered (out_valid bit set) from cycle N+1. There is no combinational in->out path.
- State machine:
  - IDLE: out_valid=0. Goes to OFFER when fill>0 (registered; the offer starts the cycle after fill becomes nonzero).
  - OFFER: out_valid = one-hot(ptr), out_data = FIFO head.
    - Transfer on out_valid[ptr] & out_ready[ptr] at an edge:
      - pop the FIFO; dispatch_cnt+1; ptr = (ptr+1) mod N_OUT (N_OUT-1 wraps to 0); stall counter cleared.
      - Stay in OFFER if fill-after>0, else go to IDLE.
    - No transfer: stall counter+1. When the counter reaches STALL_LIMIT, go to SKIP.
  - SKIP: one cycle with out_valid=0.
    - ptr advances mod N_OUT; stall counter cleared; skip_cnt+1 (saturating).
    - The word is not popped; return to OFFER to offer the same word to the next consumer.
- out_ready on non-selected bits is ignored. out_data and ptr stay stable while the offer stands.
- Multiple out_ready bits high: only bit ptr counts.
- Simultaneous push and pop when 0<fill<FIFO_DEPTH: fill unchanged, both take effect.
- Push into an empty FIFO while in IDLE: that word is the next offered; ptr is unchanged.
- A reset asserted mid-offer or mid-skip discards all FIFO contents. No word is delivered or counted on a reset edge.
- sel_idx reflects ptr in all states, including IDLE.

Test Plan:
- Reset then push 0x11,0x22,0x33,0x44,0x55,0x66 with all out_ready=1 -> delivered to consumers 0,1,2,3,4,0 in order; dispatch_cnt=6; first out_valid exactly one cycle after the first push.
- out_ready=0 throughout, push 6 words -> in_ready drops after 4 accepted; 5th word held upstream, not lost.
- Hold out_ready[1]=0 with STALL_LIMIT=15, others ready, push 0xA0,0xA1 -> 0xA0 goes to consumer 0; 0xA1 is offered to 1 for 15 cycles, then one SKIP cycle with out_valid=0, then goes to consumer 2; skip_cnt=1.
- FIFO full, and on one edge both a pop and in_valid occur -> in_ready was 0, so no push; fill goes 4->3; in_ready=1 next cycle.
- Assert rst while word 0x5A is offered and 3 words are queued -> next cycle out_valid=0, sel_idx=0, counters 0; after reset the FIFO is empty and none of the old words appear.
- 65536 deliveries -> dispatch_cnt wraps to 0. Force 300 skips -> skip_cnt holds 255.

Source files
------------

// File: rtl/rr_fanout_dispatcher.sv
// Round-robin fan-out feeder: a small input FIFO whose head word is offered to
// N_OUT consumers in turn, skipping any consumer that stalls for STALL_LIMIT cycles.
module rr_fanout_dispatcher #(
   parameter int DATA_W      = 8,
   parameter int N_OUT       = 5,
   parameter int FIFO_DEPTH  = 4,
   parameter int STALL_LIMIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [N_OUT-1:0]  out_valid,
   input  logic [N_OUT-1:0]  out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        sel_idx,
   output logic [15:0]       dispatch_cnt,
   output logic [7:0]        skip_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam logic [FW-1:0] FILL_MAX  = FW'(FIFO_DEPTH);
   localparam logic [7:0]    STALL_MAX = 8'(STALL_LIMIT);
   localparam logic [2:0]    PTR_LAST  = 3'(N_OUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_SKIP  = 2'd2
   } state_t;

   state_t            state_r, state_next_s;
   logic [2:0]        ptr_r, ptr_next_s;
   logic [7:0]        stall_r, stall_next_s;
   logic [FW-1:0]     fill_r, fill_next_s;
   logic [AW-1:0]     rd_ptr_r, wr_ptr_r, rd_next_s;
   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic              in_ready_r;
   logic [N_OUT-1:0]  out_valid_r;
   logic [DATA_W-1:0] out_data_r, head_next_s;
   logic [15:0]       dispatch_cnt_r;
   logic [7:0]        skip_cnt_r;
   logic              push_s, xfer_s, skip_inc_s;

   function automatic logic [2:0] ptr_inc(input logic [2:0] p);
      logic [2:0] r;
      if (p == PTR_LAST) begin
         r = 3'd0;
      end else begin
         r = p + 3'd1;
      end
      return r;
   endfunction

   function automatic logic [N_OUT-1:0] one_hot(input logic [2:0] p);
      logic [N_OUT-1:0] r;
      r = {N_OUT{1'b0}};
      for (int i = 0; i < N_OUT; i++) begin
         if (p == 3'(i)) begin
            r[i] = 1'b1;
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   // Handshake decode; out_valid_r is only ever one-hot(ptr) in OFFER, so other ready bits drop out
   always_comb begin
      push_s      = in_valid & in_ready_r;
      xfer_s      = (state_r == ST_OFFER) & (|(out_ready & out_valid_r));
      fill_next_s = fill_r + FW'(push_s) - FW'(xfer_s);
      rd_next_s   = rd_ptr_r + AW'(xfer_s);
      if (push_s && (wr_ptr_r == rd_next_s)) begin
         head_next_s = in_data;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Offer/skip state machine: next state, pointer and stall counter
   always_comb begin
      state_next_s = state_r;
      ptr_next_s   = ptr_r;
      stall_next_s = stall_r;
      skip_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fill_r != {FW{1'b0}}) begin
               state_next_s = ST_OFFER;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (xfer_s) begin
               ptr_next_s   = ptr_inc(ptr_r);
               stall_next_s = 8'd0;
               if (fill_next_s != {FW{1'b0}}) begin
                  state_next_s = ST_OFFER;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               stall_next_s = stall_r + 8'd1;
               if (stall_next_s == STALL_MAX) begin
                  state_next_s = ST_SKIP;
               end else begin
                  state_next_s = ST_OFFER;
               end
            end
         end
         ST_SKIP: begin
            ptr_next_s   = ptr_inc(ptr_r);
            stall_next_s = 8'd0;
            skip_inc_s   = 1'b1;
            state_next_s = ST_OFFER;
         end
         default: begin
            ptr_next_s   = 3'd0;
            stall_next_s = 8'd0;
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Control registers, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         ptr_r          <= 3'd0;
         stall_r        <= 8'd0;
         fill_r         <= {FW{1'b0}};
         rd_ptr_r       <= {AW{1'b0}};
         wr_ptr_r       <= {AW{1'b0}};
         in_ready_r     <= 1'b0;
         out_valid_r    <= {N_OUT{1'b0}};
         out_data_r     <= {DATA_W{1'b0}};
         dispatch_cnt_r <= 16'd0;
         skip_cnt_r     <= 8'd0;
      end else begin
         state_r     <= state_next_s;
         ptr_r       <= ptr_next_s;
         stall_r     <= stall_next_s;
         fill_r      <= fill_next_s;
         rd_ptr_r    <= rd_next_s;
         wr_ptr_r    <= wr_ptr_r + AW'(push_s);
         in_ready_r  <= (fill_next_s < FILL_MAX);
         out_data_r  <= head_next_s;
         if (state_next_s == ST_OFFER) begin
            out_valid_r <= one_hot(ptr_next_s);
         end else begin
            out_valid_r <= {N_OUT{1'b0}};
         end
         dispatch_cnt_r <= dispatch_cnt_r + 16'(xfer_s);
         if (skip_inc_s && (skip_cnt_r != 8'hFF)) begin
            skip_cnt_r <= skip_cnt_r + 8'd1;
         end else begin
            skip_cnt_r <= skip_cnt_r;
         end
      end
   end

   // FIFO storage; cleared on reset so out_data reads zero afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
         end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
         end
      end
   end

   assign in_ready     = in_ready_r;
   assign out_valid    = out_valid_r;
   assign out_data     = out_data_r;
   assign sel_idx      = ptr_r;
   assign dispatch_cnt = dispatch_cnt_r;
   assign skip_cnt     = skip_cnt_r;

endmodule
